// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and alu_share_arbiter.
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WIDTH   = 8
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*4-1:0]     req_op;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_carry;
  logic                     rsp_zero;
  logic                     rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one combinational ALU among NUM_REQ requesters (IDLE->EXEC->RESP).
// Define ALU_ARB_OPCHECK_EN to reject illegal opcodes (alu_sel held 0, rsp_err=1).
module alu_share_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WIDTH   = 8
) (
  input  logic               clk,
  input  logic               reset,
  alu_share_arbiter_if.slave bus,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_sel,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_carry,
  input  logic               alu_zero
);
  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SCAN_W = PTR_W + 1;
  localparam int unsigned OP_W   = 4;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              carry_q, carry_d, zero_q, zero_d, err_q, err_d;
  logic [PTR_W-1:0]  pick;
  logic [SCAN_W-1:0] scan;
  logic              found;
  logic              op_ok;
  logic [WIDTH-1:0]  a_arr  [NUM_REQ];
  logic [WIDTH-1:0]  b_arr  [NUM_REQ];
  logic [OP_W-1:0]   op_arr [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      a_arr[i]  = bus.req_a[i*WIDTH +: WIDTH];
      b_arr[i]  = bus.req_b[i*WIDTH +: WIDTH];
      op_arr[i] = bus.req_op[i*OP_W +: OP_W];
    end
  end

  // First valid requester at or above the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr_q} + SCAN_W'(k);
      if (scan >= SCAN_W'(NUM_REQ)) scan = scan - SCAN_W'(NUM_REQ);
      if (!found && bus.req_valid[scan[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = scan[PTR_W-1:0];
      end
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  always_comb begin
    case (op_q)
      4'h1, 4'h2, 4'h3, 4'h6, 4'h8, 4'hB, 4'hC: op_ok = 1'b1;
      default:                                  op_ok = 1'b0;
    endcase
  end
`else
  assign op_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready[gnt_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALU is driven only in EXEC so it sits at select 0 otherwise.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    alu_a         = '0;
    alu_b         = '0;
    alu_sel       = '0;
    case (state_q)
      IDLE: if (found) bus.req_ready[pick] = 1'b1;
      EXEC: begin
        alu_a   = a_q;
        alu_b   = b_q;
        alu_sel = op_ok ? op_q : '0;
      end
      RESP:    bus.rsp_valid[gnt_q] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    data_d  = data_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (found) begin
        gnt_d = pick;
        a_d   = a_arr[pick];
        b_d   = b_arr[pick];
        op_d  = op_arr[pick];
      end
      EXEC: if (op_ok) begin
        data_d  = alu_out;
        carry_d = alu_carry;
        zero_d  = alu_zero;
        err_d   = 1'b0;
      end else begin
        data_d  = '0;
        carry_d = 1'b0;
        zero_d  = 1'b1;
        err_d   = 1'b1;
      end
      RESP: if (bus.rsp_ready[gnt_q]) ptr_d = (gnt_q == LAST) ? '0 : gnt_q + PTR_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      gnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign bus.rsp_data  = data_q;
  assign bus.rsp_carry = carry_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vectors feed a scoreboard queue; a negedge monitor
// pops and compares each response against the hand-computed expectation.
module tb_alu_share_arbiter;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned WIDTH   = 8;
`ifdef ALU_ARB_OPCHECK_EN
  localparam logic       OPCHK    = 1'b1;
`else
  localparam logic       OPCHK    = 1'b0;
`endif

  typedef struct { logic [7:0] a; logic [7:0] b; logic [3:0] op; logic [7:0] res; logic c; logic z; logic e; } vec_t;
  typedef struct { int idx; logic [7:0] res; logic c; logic z; logic e; int hs; } exp_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_sel;
  logic       alu_carry, alu_zero;
  logic [8:0] alu_tmp;
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;
  logic       in_rsp = 1'b0;
  vec_t       q0[$];
  vec_t       q1[$];
  exp_t       sb[$];
  int         glog[$];

  alu_share_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .alu_zero  (alu_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared ALU: 1 add, 2 sub (carry=borrow), 3 and, 6 eq, 8 or, B xor, others give 0.
  always_comb begin
    alu_tmp = '0;
    case (alu_sel)
      4'h1:    alu_tmp = {1'b0, alu_a} + {1'b0, alu_b};
      4'h2:    alu_tmp = {1'b0, alu_a} - {1'b0, alu_b};
      4'h3:    alu_tmp = {1'b0, alu_a & alu_b};
      4'h6:    alu_tmp = {8'h00, alu_a == alu_b};
      4'h8:    alu_tmp = {1'b0, alu_a | alu_b};
      4'hB:    alu_tmp = {1'b0, alu_a ^ alu_b};
      default: alu_tmp = '0;
    endcase
  end
  assign alu_out   = alu_tmp[7:0];
  assign alu_carry = alu_tmp[8];
  assign alu_zero  = (alu_tmp[7:0] == 8'h00);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                              input logic [7:0] res, input logic c, input logic z, input logic e);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.res = res; v.c = c; v.z = z; v.e = e;
    return v;
  endfunction

  function automatic exp_t to_exp(input vec_t v, input int idx, input int hs);
    exp_t x;
    x.idx = idx; x.res = v.res; x.c = v.c; x.z = v.z; x.e = v.e; x.hs = hs;
    return x;
  endfunction

  // Response monitor: every cycle a response is shown it must match the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      in_rsp <= 1'b0;
    end else if (bus.rsp_valid != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
      end else begin
        e = sb[0];
        if (!in_rsp) chk("rsp_latency", cyc, e.hs + 2);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(1 << e.idx));
        chk("rsp_data", 32'(bus.rsp_data), 32'(e.res));
        chk("rsp_carry", 32'(bus.rsp_carry), 32'(e.c));
        chk("rsp_zero", 32'(bus.rsp_zero), 32'(e.z));
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.e));
        chk("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
        if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
          void'(sb.pop_front());
          in_rsp <= 1'b0;
        end else begin
          in_rsp <= 1'b1;
        end
      end
    end
  end

  // Presents the heads of q0/q1 until every queued op has been accepted.
  task automatic serve();
    int guard = 0;
    while ((q0.size() > 0 || q1.size() > 0) && guard < 200) begin
      bus.req_valid[0] = (q0.size() > 0);
      bus.req_valid[1] = (q1.size() > 0);
      if (q0.size() > 0) begin
        bus.req_a[7:0] = q0[0].a; bus.req_b[7:0] = q0[0].b; bus.req_op[3:0] = q0[0].op;
      end
      if (q1.size() > 0) begin
        bus.req_a[15:8] = q1[0].a; bus.req_b[15:8] = q1[0].b; bus.req_op[7:4] = q1[0].op;
      end
      @(negedge clk);
      if ((bus.req_ready & ~bus.req_valid) != '0) chk("ready_without_valid", 32'(bus.req_ready), 32'(bus.req_ready & bus.req_valid));
      if (bus.req_valid[0] && bus.req_ready[0]) begin
        sb.push_back(to_exp(q0[0], 0, cyc));
        glog.push_back(0);
        void'(q0.pop_front());
      end else if (bus.req_valid[1] && bus.req_ready[1]) begin
        sb.push_back(to_exp(q1[0], 1, cyc));
        glog.push_back(1);
        void'(q1.pop_front());
      end
      @(posedge clk);
      #1;
      guard++;
    end
    bus.req_valid = '0;
    chk("serve_done", 32'(guard < 200), 32'd1);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    chk("drain_done", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_order(input int n, input int o0, input int o1, input int o2, input int o3);
    int exp_ord[4];
    exp_ord = '{o0, o1, o2, o3};
    chk("grant_count", glog.size(), n);
    for (int i = 0; i < n && i < glog.size(); i++) chk("grant_order", glog[i], exp_ord[i]);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_flags", {bus.rsp_data, bus.rsp_carry, bus.rsp_zero, bus.rsp_err}, 32'd0);
    chk("rst_alu", {alu_a, alu_b, alu_sel}, 32'd0);

    // Both requesters valid back-to-back from reset release: strict alternation.
    q0.push_back(mk(8'h01, 8'h02, 4'h1, 8'h03, 1'b0, 1'b0, 1'b0));
    q0.push_back(mk(8'h10, 8'h10, 4'h2, 8'h00, 1'b0, 1'b1, 1'b0));
    q1.push_back(mk(8'hAA, 8'h55, 4'hB, 8'hFF, 1'b0, 1'b0, 1'b0));
    q1.push_back(mk(8'h00, 8'h00, 4'h8, 8'h00, 1'b0, 1'b1, 1'b0));
    @(posedge clk);
    #1 reset = 1'b0;
    serve();
    wait_drain();
    chk_order(4, 0, 1, 0, 1);

    // ADD with carry out, ALU inputs visible in EXEC.
    q0.push_back(mk(8'hF0, 8'h20, 4'h1, 8'h10, 1'b1, 1'b0, 1'b0));
    serve();
    chk("exec_alu_a", 32'(alu_a), 32'hF0);
    chk("exec_alu_b", 32'(alu_b), 32'h20);
    chk("exec_alu_sel", 32'(alu_sel), 32'h1);
    wait_drain();
    chk("idle_alu_sel", 32'(alu_sel), 32'd0);

    // SUB with borrow then EQ on requester 1.
    q1.push_back(mk(8'h05, 8'h07, 4'h2, 8'hFE, 1'b1, 1'b0, 1'b0));
    q1.push_back(mk(8'h33, 8'h33, 4'h6, 8'h01, 1'b0, 1'b0, 1'b0));
    serve();
    wait_drain();

    // Response stalled: data held, no new grant while req1 waits.
    bus.rsp_ready = '0;
    q0.push_back(mk(8'hF0, 8'h3C, 4'h3, 8'h30, 1'b0, 1'b0, 1'b0));
    serve();
    glog.delete();
    q1.push_back(mk(8'hFF, 8'h01, 4'h1, 8'h00, 1'b1, 1'b1, 1'b0));
    fork
      begin
        repeat (6) @(posedge clk);
        #2 bus.rsp_ready = '1;
      end
    join_none
    serve();
    wait_drain();
    chk_order(1, 1, 0, 0, 0);

    // Reset during EXEC aborts the op and returns the pointer to requester 0.
    q0.push_back(mk(8'h01, 8'h01, 4'h1, 8'h02, 1'b0, 1'b0, 1'b0));
    serve();
    wait_drain();
    q0.push_back(mk(8'h02, 8'h02, 4'h1, 8'h04, 1'b0, 1'b0, 1'b0));
    serve();
    chk("abort_exec_alu_a", 32'(alu_a), 32'h02);
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(bus.req_ready), 32'd0);
    chk("abort_alu", {alu_a, alu_b, alu_sel}, 32'd0);
    chk("abort_rsp_flags", {bus.rsp_data, bus.rsp_carry, bus.rsp_zero, bus.rsp_err}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    glog.delete();
    q0.push_back(mk(8'h07, 8'h08, 4'h1, 8'h0F, 1'b0, 1'b0, 1'b0));
    q1.push_back(mk(8'h00, 8'h01, 4'h2, 8'hFF, 1'b1, 1'b0, 1'b0));
    serve();
    wait_drain();
    chk_order(2, 0, 1, 0, 0);

    // Opcode 5: rejected when the check is built in, forwarded otherwise.
    q0.push_back(mk(8'h12, 8'h34, 4'h5, 8'h00, 1'b0, 1'b1, OPCHK));
    serve();
    chk("op5_alu_sel", 32'(alu_sel), OPCHK ? 32'd0 : 32'd5);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
